game_state_ctrl: RTL and testbench

- Synchronous game-flow controller and score/lives keeper. It sits directly upstream of the scoreboard generator and drives that generator's score0/score1/lives digit inputs.
- Converts raw collision/miss event levels from the playfield logic into clean, single-count BCD score and lives updates.
- Sequences attract, serve, play and game-over phases, timed in video frames counted from vsync.
- Clocked by the VGA pixel clock, so every update is edge-safe. The older asynchronous counter-per-event approach is not used.

---
 rtl/game_state_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_game_state_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// game_state_ctrl
//   Game-flow controller and score/lives keeper feeding the scoreboard
//   generator. Raw playfield event levels are registered, rising-edge
//   detected and turned into single-count BCD score and lives updates.
//   Phases (IDLE, SERVE, PLAY, GAMEOVER) are timed in video frames counted
//   from vsync.
//
// Ports
//   clk           pixel clock
//   reset         asynchronous, active-high
//   vsync         vsync from the sync generator
//   start_btn     start request level (synchronous to clk)
//   score_evt     scoring collision level from playfield
//   miss_evt      ball-lost level from playfield
//   score0/1      BCD ones / tens digit
//   lives         remaining lives, binary 0..9
//   ball_enable   high only in PLAY
//   serve_active  high only in SERVE
//   game_over     high only in GAMEOVER
module game_state_ctrl #(
    parameter int unsigned START_LIVES     = 3,
    parameter int unsigned SERVE_FRAMES    = 60,
    parameter int unsigned GAMEOVER_FRAMES = 180,
    parameter logic        VSYNC_ACTIVE    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       start_btn,
    input  logic       score_evt,
    input  logic       miss_evt,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic [3:0] lives,
    output logic       ball_enable,
    output logic       serve_active,
    output logic       game_over
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVE,
        ST_PLAY,
        ST_GAMEOVER
    } state_t;

    localparam logic [3:0] LIVES_INIT = 4'(START_LIVES);
    localparam logic [7:0] SERVE_LEN  = 8'(SERVE_FRAMES);
    localparam logic [7:0] GO_LEN     = 8'(GAMEOVER_FRAMES);

    // Two register stages per input: the first samples the raw level, the
    // second holds the previous sample. Edges are taken between them, so an
    // update lands one clk after the edge is sampled.
    logic       vs_q, vs_prev_q;
    logic       start_q, start_prev_q;
    logic       score_q, score_prev_q;
    logic       miss_q, miss_prev_q;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] score0_q, score0_d;
    logic [3:0] score1_q, score1_d;
    logic [3:0] lives_q, lives_d;
    logic       ball_q, serve_q, go_q;

    logic       frame_tick, start_pulse, score_pulse, miss_pulse;
    logic [7:0] cnt_inc;

    assign frame_tick  = (vs_q == VSYNC_ACTIVE) && (vs_prev_q != VSYNC_ACTIVE);
    assign start_pulse = start_q & ~start_prev_q;
    assign score_pulse = score_q & ~score_prev_q;
    assign miss_pulse  = miss_q  & ~miss_prev_q;
    assign cnt_inc     = cnt_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        score0_d = score0_q;
        score1_d = score1_q;
        lives_d  = lives_q;

        case (state_q)
            ST_IDLE, ST_GAMEOVER: begin
                if (start_pulse) begin
                    // A start in GAMEOVER restarts exactly as from IDLE.
                    score0_d = 4'd0;
                    score1_d = 4'd0;
                    lives_d  = LIVES_INIT;
                    cnt_d    = 8'd0;
                    state_d  = ST_SERVE;
                end else if (state_q == ST_GAMEOVER && frame_tick) begin
                    if (cnt_inc == GO_LEN) begin
                        cnt_d   = 8'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            ST_SERVE: begin
                if (frame_tick) begin
                    if (cnt_inc == SERVE_LEN) begin
                        cnt_d   = 8'd0;
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            ST_PLAY: begin
                if (score_pulse) begin
                    // Saturate at 99; digits stay within 0..9.
                    if (score0_q == 4'd9) begin
                        if (score1_q != 4'd9) begin
                            score0_d = 4'd0;
                            score1_d = score1_q + 4'd1;
                        end
                    end else begin
                        score0_d = score0_q + 4'd1;
                    end
                end
                // A miss with no lives left cannot happen; guard anyway.
                if (miss_pulse && lives_q != 4'd0) begin
                    lives_d = lives_q - 4'd1;
                    cnt_d   = 8'd0;
                    state_d = (lives_q == 4'd1) ? ST_GAMEOVER : ST_SERVE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_q         <= ~VSYNC_ACTIVE;
            vs_prev_q    <= ~VSYNC_ACTIVE;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            score_q      <= 1'b0;
            score_prev_q <= 1'b0;
            miss_q       <= 1'b0;
            miss_prev_q  <= 1'b0;
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            score0_q     <= 4'd0;
            score1_q     <= 4'd0;
            lives_q      <= LIVES_INIT;
            ball_q       <= 1'b0;
            serve_q      <= 1'b0;
            go_q         <= 1'b0;
        end else begin
            vs_q         <= vsync;
            vs_prev_q    <= vs_q;
            start_q      <= start_btn;
            start_prev_q <= start_q;
            score_q      <= score_evt;
            score_prev_q <= score_q;
            miss_q       <= miss_evt;
            miss_prev_q  <= miss_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score0_q     <= score0_d;
            score1_q     <= score1_d;
            lives_q      <= lives_d;
            // Flags decoded from the next state so they track state_q exactly.
            ball_q       <= (state_d == ST_PLAY);
            serve_q      <= (state_d == ST_SERVE);
            go_q         <= (state_d == ST_GAMEOVER);
        end
    end

    assign score0       = score0_q;
    assign score1       = score1_q;
    assign lives        = lives_q;
    assign ball_enable  = ball_q;
    assign serve_active = serve_q;
    assign game_over    = go_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Testbench for game_state_ctrl: directed scenarios plus a random phase,
// checked every cycle against a behavioural model that keeps the score as a
// plain integer, and pinned by literal expectations at key points.
module tb_game_state_ctrl;

    localparam int SL = 3;
    localparam int SF = 60;
    localparam int GF = 180;
    localparam int FRAME = 8;   // clk cycles per generated vsync frame

    localparam int M_IDLE = 0;
    localparam int M_SERVE = 1;
    localparam int M_PLAY = 2;
    localparam int M_GO = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b1;
    logic       start_btn = 1'b0;
    logic       score_evt = 1'b0;
    logic       miss_evt = 1'b0;
    logic [3:0] score0, score1, lives;
    logic       ball_enable, serve_active, game_over;

    int pass_cnt = 0;
    int total = 0;

    game_state_ctrl dut (
        .clk(clk), .reset(reset), .vsync(vsync), .start_btn(start_btn),
        .score_evt(score_evt), .miss_evt(miss_evt),
        .score0(score0), .score1(score1), .lives(lives),
        .ball_enable(ball_enable), .serve_active(serve_active),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    // vsync: active-low pulse of 2 cycles every FRAME cycles.
    initial begin
        int vcyc;
        vcyc = 0;
        forever begin
            @(negedge clk);
            vsync = (vcyc < 2) ? 1'b0 : 1'b1;
            vcyc = (vcyc == FRAME - 1) ? 0 : vcyc + 1;
        end
    end

    // ---------------- behavioural model ----------------
    int   m_st, m_score, m_lives, m_cnt;
    int   n_st, n_score, n_lives, n_cnt;
    logic vs1, vs2;              // last two sampled vsync values
    logic [2:0] h1, h2;          // last two samples of {start, score, miss}
    logic tick, stp, scp, msp;

    assign tick = (vs1 == 1'b0) && (vs2 == 1'b1);
    assign stp  = h1[2] & ~h2[2];
    assign scp  = h1[1] & ~h2[1];
    assign msp  = h1[0] & ~h2[0];

    always_comb begin
        n_st = m_st; n_score = m_score; n_lives = m_lives; n_cnt = m_cnt;
        if ((m_st == M_IDLE || m_st == M_GO) && stp) begin
            n_st = M_SERVE; n_score = 0; n_lives = SL; n_cnt = 0;
        end else if (m_st == M_GO && tick) begin
            if (m_cnt + 1 == GF) begin n_st = M_IDLE; n_cnt = 0; end
            else n_cnt = m_cnt + 1;
        end else if (m_st == M_SERVE && tick) begin
            if (m_cnt + 1 == SF) begin n_st = M_PLAY; n_cnt = 0; end
            else n_cnt = m_cnt + 1;
        end else if (m_st == M_PLAY) begin
            if (scp) n_score = (m_score >= 99) ? 99 : m_score + 1;
            if (msp && m_lives > 0) begin
                n_lives = m_lives - 1;
                n_cnt = 0;
                n_st = (m_lives - 1 == 0) ? M_GO : M_SERVE;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st <= M_IDLE; m_score <= 0; m_lives <= SL; m_cnt <= 0;
            vs1 <= 1'b1; vs2 <= 1'b1; h1 <= 3'b000; h2 <= 3'b000;
        end else begin
            m_st <= n_st; m_score <= n_score; m_lives <= n_lives; m_cnt <= n_cnt;
            vs2 <= vs1; vs1 <= vsync;
            h2 <= h1; h1 <= {start_btn, score_evt, miss_evt};
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                int act, exp;
                act = {score1, score0, lives, ball_enable, serve_active, game_over};
                exp = {4'(m_score / 10), 4'(m_score % 10), 4'(m_lives),
                       m_st == M_PLAY, m_st == M_SERVE, m_st == M_GO};
                chk("model_cmp", act, exp);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 start, 1 score, 2 miss, 3 score+miss together
    task automatic pulse(input int which);
        @(negedge clk);
        start_btn = (which == 0);
        score_evt = (which == 1 || which == 3);
        miss_evt  = (which == 2 || which == 3);
        cyc(3);
        start_btn = 1'b0; score_evt = 1'b0; miss_evt = 1'b0;
        cyc(3);
    endtask

    // Wait (bounded) for {ball_enable, serve_active, game_over} == want.
    task automatic wait_flags(input string name, input logic [2:0] want, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #2;
            if ({ball_enable, serve_active, game_over} == want) break;
        end
        chk(name, {ball_enable, serve_active, game_over}, want);
    endtask

    initial begin
        // Reset with score_evt high across release.
        reset = 1'b1; score_evt = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(3);
        chk("rst_score", {score1, score0}, 8'h00);
        chk("rst_lives", lives, 3);
        chk("rst_flags", {ball_enable, serve_active, game_over}, 0);
        score_evt = 1'b0; cyc(2); score_evt = 1'b1; cyc(3); score_evt = 1'b0;
        chk("idle_score_ignored", {score1, score0}, 8'h00);

        // Game 1
        pulse(0);
        chk("serve_after_start", serve_active, 1);
        repeat (3) pulse(1);
        chk("serve_score_ignored", {score1, score0}, 8'h00);
        wait_flags("reach_play1", 3'b100, SF * FRAME + 64);
        repeat (9) pulse(1);
        chk("score_09", {score1, score0}, 8'h09);
        pulse(1);
        chk("score_10", {score1, score0}, 8'h10);
        pulse(2);
        chk("miss_lives2", lives, 2);
        chk("miss_to_serve", serve_active, 1);
        wait_flags("reach_play2", 3'b100, SF * FRAME + 64);
        pulse(2);
        chk("miss_lives1", lives, 1);
        wait_flags("reach_play3", 3'b100, SF * FRAME + 64);
        pulse(3);
        chk("simul_score", {score1, score0}, 8'h11);
        chk("simul_lives", lives, 0);
        chk("simul_gameover", game_over, 1);
        wait_flags("gameover_to_idle", 3'b000, GF * FRAME + 64);
        chk("idle_score_kept", {score1, score0}, 8'h11);

        // Game 2: saturation and restart from GAMEOVER
        pulse(0);
        chk("restart_score", {score1, score0}, 8'h00);
        chk("restart_lives", lives, 3);
        wait_flags("g2_play", 3'b100, SF * FRAME + 64);
        repeat (99) pulse(1);
        chk("score_99", {score1, score0}, 8'h99);
        pulse(1);
        chk("score_sat", {score1, score0}, 8'h99);
        for (int k = 0; k < 3; k++) begin
            pulse(2);
            if (k < 2) wait_flags("g2_replay", 3'b100, SF * FRAME + 64);
        end
        chk("g2_gameover", game_over, 1);
        cyc(10 * FRAME);
        pulse(0);
        chk("go_start_serve", serve_active, 1);
        chk("go_start_score", {score1, score0}, 8'h00);
        chk("go_start_lives", lives, 3);

        // Random phase
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            start_btn = ($urandom_range(99) < 3);
            score_evt = ($urandom_range(3) == 0);
            miss_evt  = ($urandom_range(49) == 0);
        end
        start_btn = 1'b0; score_evt = 1'b0; miss_evt = 1'b0;
        cyc(4);

        // Asynchronous reset in PLAY, between clock edges
        @(negedge clk); reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        pulse(0);
        wait_flags("ar_play", 3'b100, SF * FRAME + 64);
        repeat (3) pulse(1);
        chk("ar_pre_score", {score1, score0}, 8'h03);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("ar_flags", {ball_enable, serve_active, game_over}, 0);
        chk("ar_score", {score1, score0}, 8'h00);
        chk("ar_lives", lives, 3);
        @(negedge clk); reset = 1'b0;
        cyc(5);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
